multdiv_unit: RTL



---
 rtl/multdiv_unit.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/multdiv_unit.sv
// multdiv_unit: iterative 32-bit signed multiply/divide unit for the execute stage.
//
// A one-cycle start pulse (ctrl_MULT or ctrl_DIV) latches both operands. The unit then
// runs 32 radix-2 iterations, either shift-add multiply or restoring divide, on operand
// magnitudes and fixes up the sign at the end. data_resultRDY strobes for one cycle when
// data_result / data_exception are valid. Both outputs hold until the next completion.
// A start in any state aborts the current operation and restarts it. MULT wins over DIV.
//
// Ports:
//   clock, reset        rising-edge clock; asynchronous active-high reset
//   data_operandA/B     signed multiplicand/multiplier or dividend/divisor
//   ctrl_MULT/ctrl_DIV  one-cycle start pulses
//   data_result         low 32 bits of the product, or the quotient (truncated toward zero)
//   data_exception      multiply overflow, divide-by-zero or 0x80000000 / -1 overflow
//   data_resultRDY      one-cycle valid strobe
//
// Configuration macro:
//   MULTDIV_EARLY_DIV0_EN  when defined, a divide by zero completes one cycle after start
//                          instead of running all 32 iterations.

module multdiv_unit (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] data_operandA,
  input  logic [31:0] data_operandB,
  input  logic        ctrl_MULT,
  input  logic        ctrl_DIV,
  output logic [31:0] data_result,
  output logic        data_exception,
  output logic        data_resultRDY
);

  typedef enum logic [1:0] {StIdle, StMul, StDiv, StDone} state_e;

  state_e      state_q;
  logic [4:0]  count_q;
  // Multiply: opnd_q = |A|, acc_q = {partial product, remaining multiplier bits}.
  // Divide:   opnd_q = |B|, acc_q = {partial remainder, dividend/quotient bits}.
  logic [31:0] opnd_q;
  logic [63:0] acc_q;
  logic        neg_q;
  logic        div_zero_q;
  logic        div_ovf_q;
  logic [31:0] result_q;
  logic        exc_q;
  logic        rdy_q;

  logic        start;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic        last;
  logic [32:0] mul_sum;
  logic [63:0] mul_next;
  logic [63:0] prod_signed;
  logic        mul_exc;
  logic [32:0] div_sh;
  logic        div_ge;
  logic [31:0] div_sub;
  logic [63:0] div_next;
  logic [31:0] quo_signed;

  always_comb begin
    start = ctrl_MULT | ctrl_DIV;
    // Negating 0x80000000 yields 0x80000000, which is the correct unsigned magnitude.
    a_mag = data_operandA[31] ? (~data_operandA + 32'd1) : data_operandA;
    b_mag = data_operandB[31] ? (~data_operandB + 32'd1) : data_operandB;
    last  = (count_q == 5'd31);

    // Shift-add step: conditionally add the multiplicand into the high half, then shift
    // the 65-bit {carry, high, low} right by one. The multiplier bit falls out of bit 0.
    mul_sum     = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opnd_q} : 33'd0);
    mul_next    = {mul_sum, acc_q[31:1]};
    prod_signed = neg_q ? (~mul_next + 64'd1) : mul_next;
    // The product fits in signed 32 bits only if bits [63:31] are all equal.
    mul_exc     = !((&prod_signed[63:31]) || !(|prod_signed[63:31]));

    // Restoring step: shift the next dividend bit into the remainder, subtract when it fits.
    // The remainder stays below the divisor, so the difference always fits in 32 bits.
    div_sh     = {acc_q[63:32], acc_q[31]};
    div_ge     = (div_sh >= {1'b0, opnd_q});
    div_sub    = div_sh[31:0] - opnd_q;
    div_next   = {(div_ge ? div_sub : div_sh[31:0]), acc_q[30:0], div_ge};
    quo_signed = neg_q ? (~div_next[31:0] + 32'd1) : div_next[31:0];
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      count_q    <= 5'd0;
      opnd_q     <= 32'd0;
      acc_q      <= 64'd0;
      neg_q      <= 1'b0;
      div_zero_q <= 1'b0;
      div_ovf_q  <= 1'b0;
      result_q   <= 32'd0;
      exc_q      <= 1'b0;
      rdy_q      <= 1'b0;
    end else begin
      rdy_q <= 1'b0;
      if (start) begin
        count_q    <= 5'd0;
        neg_q      <= data_operandA[31] ^ data_operandB[31];
        div_zero_q <= (data_operandB == 32'd0);
        div_ovf_q  <= (data_operandA == 32'h8000_0000) && (data_operandB == 32'hFFFF_FFFF);
        if (ctrl_MULT) begin
          state_q <= StMul;
          opnd_q  <= a_mag;
          acc_q   <= {32'd0, b_mag};
        end else begin
          state_q <= StDiv;
          opnd_q  <= b_mag;
          acc_q   <= {32'd0, a_mag};
        end
      end else begin
        unique case (state_q)
          StIdle: ;
          StMul: begin
            acc_q   <= mul_next;
            count_q <= count_q + 5'd1;
            if (last) begin
              state_q  <= StDone;
              result_q <= prod_signed[31:0];
              exc_q    <= mul_exc;
              rdy_q    <= 1'b1;
            end
          end
          StDiv: begin
`ifdef MULTDIV_EARLY_DIV0_EN
            if (div_zero_q) begin
              state_q  <= StDone;
              result_q <= 32'd0;
              exc_q    <= 1'b1;
              rdy_q    <= 1'b1;
            end else begin
`else
            begin
`endif
              acc_q   <= div_next;
              count_q <= count_q + 5'd1;
              if (last) begin
                state_q  <= StDone;
                rdy_q    <= 1'b1;
                if (div_zero_q) begin
                  result_q <= 32'd0;
                  exc_q    <= 1'b1;
                end else begin
                  result_q <= quo_signed;
                  exc_q    <= div_ovf_q;
                end
              end
            end
          end
          StDone: state_q <= StIdle;
        endcase
      end
    end
  end

  assign data_result    = result_q;
  assign data_exception = exc_q;
  assign data_resultRDY = rdy_q;

endmodule
